// File: rtl/alu_seq.sv
// Multi-byte operation sequencer: steps a shared 8-bit ALU through BYTES-wide operands one byte per cycle.
// Defining ALU_SEQ_ZFLAG_EN adds a registered zero flag output.
module alu_seq #(
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [8*BYTES-1:0] opa,
  input  logic [8*BYTES-1:0] opb,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [8*BYTES-1:0] result,
  output logic               cout,
`ifdef ALU_SEQ_ZFLAG_EN
  output logic               zero,
`endif
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [3:0]         alu_op,
  output logic               alu_cin,
  input  logic [7:0]         alu_q,
  input  logic               alu_cout
);
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [IDX_W-1:0]   sel;
  logic [3:0]         op_reg;
  logic               cin_reg;
  logic               chain_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [8*BYTES-1:0] opa_reg;
  logic [8*BYTES-1:0] opb_reg;
  logic [8*BYTES-1:0] result_reg;
  logic [8*BYTES-1:0] result_next;
  logic [7:0]         opa_bytes [BYTES];
  logic [7:0]         opb_bytes [BYTES];
  logic               first;
  logic               last;
  logic               shr;
`ifdef ALU_SEQ_ZFLAG_EN
  logic               zero_reg;
`endif

  assign shr   = (op_reg[3:2] == 2'b11);
  assign first = (idx_reg == '0);
  assign last  = (idx_reg == IDX_W'(BYTES - 1));
  // Shift right walks MSB to LSB so the shifted-out bit feeds the next lower byte.
  assign sel   = shr ? (IDX_W'(BYTES - 1) - idx_reg) : idx_reg;

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_byte
      assign opa_bytes[gi] = opa_reg[gi*8 +: 8];
      assign opb_bytes[gi] = opb_reg[gi*8 +: 8];
      assign result_next[gi*8 +: 8] = (state_reg == RUN && sel == IDX_W'(gi)) ?
                                      alu_q : result_reg[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = '0;
    alu_cin = 1'b0;
    if (state_reg == RUN) begin
      alu_a = opa_bytes[sel];
      alu_b = opb_bytes[sel];
      if (first || op_reg[3:2] == 2'b00) begin
        alu_op  = op_reg;
        alu_cin = cin_reg;
      end else if (op_reg[3:2] == 2'b01) begin
        alu_op  = {op_reg[3:1], 1'b1};
        alu_cin = chain_reg;
      end else begin
        alu_op  = {op_reg[3:2], 2'b01};
        alu_cin = chain_reg;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      op_reg     <= '0;
      cin_reg    <= 1'b0;
      chain_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      result_reg <= '0;
`ifdef ALU_SEQ_ZFLAG_EN
      zero_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            opa_reg   <= opa;
            opb_reg   <= opb;
            op_reg    <= op;
            cin_reg   <= cin;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          result_reg <= result_next;
          chain_reg  <= alu_cout;
          if (last) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
`ifdef ALU_SEQ_ZFLAG_EN
            zero_reg  <= (result_next == '0);
`endif
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;
  assign cout   = chain_reg;
`ifdef ALU_SEQ_ZFLAG_EN
  assign zero   = zero_reg;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: byte-wide ALU model on the ALU ports, whole-word reference model for results.
module tb_alu_seq;
  localparam int BYTES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] opa, opb;
  logic        cin;
  logic        busy, done, cout;
  logic [31:0] result;
  logic [7:0]  alu_a, alu_b, alu_q;
  logic [3:0]  alu_op;
  logic        alu_cin, alu_cout;
`ifdef ALU_SEQ_ZFLAG_EN
  logic        zero;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.BYTES(BYTES)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout),
`ifdef ALU_SEQ_ZFLAG_EN
    .zero(zero),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_q(alu_q), .alu_cout(alu_cout)
  );

  // 8-bit ALU: sub-function bit0 selects carry/shift-in from alu_cin, otherwise bit1 is the constant in.
  logic [8:0] alu_sum;
  logic       alu_ci;
  always_comb begin
    alu_ci   = alu_op[0] ? alu_cin : alu_op[1];
    alu_sum  = {1'b0, alu_a} + {1'b0, (alu_op[1] ? ~alu_b : alu_b)} + {8'd0, alu_ci};
    alu_q    = 8'd0;
    alu_cout = 1'b0;
    case (alu_op[3:2])
      2'b00: begin
        case (alu_op[1:0])
          2'b00:   alu_q = alu_a & alu_b;
          2'b01:   alu_q = alu_a | alu_b;
          2'b10:   alu_q = alu_a ^ alu_b;
          default: alu_q = ~(alu_a | alu_b);
        endcase
      end
      2'b01:   {alu_cout, alu_q} = alu_sum;
      2'b10:   {alu_cout, alu_q} = {alu_a, alu_ci};
      default: begin
        alu_q    = {alu_ci, alu_a[7:1]};
        alu_cout = alu_a[0];
      end
    endcase
  end

  // Whole-word result {cout, result} of one operation.
  function automatic logic [32:0] ref_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                         input logic c);
    logic ci;
    ci = o[0] ? c : o[1];
    case (o[3:2])
      2'b00: begin
        case (o[1:0])
          2'b00:   return {1'b0, a & b};
          2'b01:   return {1'b0, a | b};
          2'b10:   return {1'b0, a ^ b};
          default: return {1'b0, ~(a | b)};
        endcase
      end
      2'b01:   return {1'b0, a} + {1'b0, (o[1] ? ~b : b)} + {32'd0, ci};
      2'b10:   return {a, ci};
      default: return {a[0], ci, a[31:1]};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation; poke re-asserts start two cycles after acceptance.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input bit poke);
    logic [32:0] exp_v;
    logic [3:0]  eop;
    int n, busy_n, bsel;
    exp_v = ref_op(o, a, b, c);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; cin = c;
    @(negedge clk);
    start = 1'b0; op = 4'($urandom); opa = $urandom; opb = $urandom; cin = 1'($urandom);
    n = 1;
    busy_n = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) begin
        bsel = (o[3:2] == 2'b11) ? (BYTES - 1 - busy_n) : busy_n;
        eop  = (busy_n == 0 || o[3:2] == 2'b00) ? o :
               (o[3:2] == 2'b01) ? {o[3:1], 1'b1} : {o[3:2], 2'b01};
        check("alu_a", 64'(alu_a), 64'(a[bsel*8 +: 8]));
        check("alu_b", 64'(alu_b), 64'(b[bsel*8 +: 8]));
        check("alu_op", 64'(alu_op), 64'(eop));
        busy_n++;
      end
      if (poke) start = (n == 2);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("latency", 64'(n), 64'(BYTES + 1));
    check("busy_cycles", 64'(busy_n), 64'(BYTES));
    check("busy_at_done", 64'(busy), 64'd0);
    check("result", 64'(result), 64'(exp_v[31:0]));
    check("cout", 64'(cout), 64'(exp_v[32]));
`ifdef ALU_SEQ_ZFLAG_EN
    check("zero", 64'(zero), 64'(exp_v[31:0] == 32'd0));
`endif
    $display("op=%b opa=%h opb=%h cin=%0d -> result=%h cout=%0d", o, a, b, c, result, cout);
  endtask

  initial begin
    int done_n, busy_n;
    logic [31:0] held;
    rst = 1'b1; start = 1'b0; op = 4'd0; opa = 32'd0; opb = 32'd0; cin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_alu", 64'({alu_a, alu_b, alu_op, alu_cin}), 64'd0);
    rst = 1'b0;

    run_op(4'b0100, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
    run_op(4'b0100, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    run_op(4'b1000, 32'h80000001, 32'h00000000, 1'b0, 1'b0);
    run_op(4'b1100, 32'h80000001, 32'h00000000, 1'b0, 1'b0);
    run_op(4'b0110, 32'h00000000, 32'h00000001, 1'b0, 1'b0);

    // Start pulsed while busy must be ignored.
    run_op(4'b0100, 32'h12340F0F, 32'h0000F0F1, 1'b0, 1'b1);
    held = result;
    done_n = 0;
    busy_n = 0;
    repeat (8) begin
      @(negedge clk);
      done_n += int'(done);
      busy_n += int'(busy);
    end
    check("ignored_start_done", 64'(done_n), 64'd0);
    check("ignored_start_busy", 64'(busy_n), 64'd0);
    check("ignored_start_result", 64'(result), 64'(held));

    // Reset during RUN aborts and clears.
    @(negedge clk);
    start = 1'b1; op = 4'b0100; opa = 32'h12345678; opb = 32'h11111111; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_cout", 64'(cout), 64'd0);
    check("abort_alu_op", 64'(alu_op), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    done_n = 0;
    repeat (8) begin
      @(negedge clk);
      done_n += int'(done);
    end
    check("abort_no_done", 64'(done_n), 64'd0);
    run_op(4'b0100, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_op(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-byte operation sequencer for the 8-bit ALU. It accepts one operation on BYTES-wide operands, steps the ALU through the operands one byte per cycle, and chains the carry/shift bit between bytes. It assembles the full-width result and reports it with a start/busy/done handshake. It sits between the CPU control unit and the single shared 8-bit ALU instance, and owns all ALU input ports while busy.

## Interface
- BYTES, default 4: operand width in bytes; legal range is 2..8.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation. Sampled only in IDLE.
- op  input  4  ALU opcode:
  - op[3:2]: 00 bitwise, 01 add/sub, 10 shift left, 11 shift right.
  - op[1:0]: sub-function.
- opa, opb  input  8*BYTES  operands.
- cin  input  1  carry/shift-in applied to the first byte.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; result and cout are valid from this cycle onward.
- result  output  8*BYTES  assembled result; held until the next accepted start.
- cout  output  1  carry/shift-out of the final byte processed.
- alu_a, alu_b  output  8  current byte to the ALU.
- alu_op  output  4  opcode to the ALU.
- alu_cin  output  1  carry-in to the ALU.
- alu_q  input  8  ALU result byte; combinational from alu_* in the same cycle.
- alu_cout  input  1  ALU carry-out; combinational from alu_* in the same cycle.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start. opa, opb, op and cin are latched, and the byte index is cleared.
  - RUN stays in RUN for BYTES cycles, processing one byte per cycle.
  - RUN -> DONE after the byte with index BYTES-1.
  - DONE -> IDLE unconditionally after one cycle.
- Byte order:
  - Shift right (op[3:2]=11) processes bytes MSB first.
  - All other operations process bytes LSB first.
- alu_a and alu_b present the selected byte of the latched opa and opb.
- Opcode and carry for the first byte processed:
  - alu_op = latched op.
  - alu_cin = latched cin.
- Opcode and carry for later bytes:
  - Bitwise: alu_op = latched op; alu_cin = latched cin.
  - Add/sub: alu_op = {latched op[3:1], 1}, i.e. the carry-in variant. alu_cin = chain flop.
  - Shifts: alu_op = {latched op[3:2], 01}, which selects carry as the new bit. alu_cin = chain flop.
- Chain flop:
  - Captures alu_cout at the end of every RUN cycle.
  - cout = chain flop value after the final byte.
- Each RUN cycle writes alu_q into the matching result byte on the clock edge.
- In IDLE and DONE: alu_a = 0, alu_b = 0, alu_op = 0, alu_cin = 0.
- start while busy or in DONE is ignored. There is no queueing.
- Operand or op changes after acceptance have no effect, because the latched copies are used.

## Timing
- Latency: start sampled high at edge 0 gives done high in cycle BYTES+1. Total is BYTES+2 cycles before the next start can be accepted in IDLE.
- busy is high for exactly BYTES cycles.
- done is high for exactly one cycle and is never asserted together with busy.
- result and cout:
  - Update byte-wise during RUN.
  - Are stable and valid from done until the edge after the next accepted start.
- Reset values, applied asynchronously on rst:
  - state = IDLE.
  - busy = 0, done = 0, result = 0, cout = 0.
  - all alu_* outputs = 0; chain flop = 0.
- Reset mid-operation aborts immediately. No done is produced and the partial result is discarded (cleared to 0).
- start held high continuously: a new operation is accepted on every return to IDLE.

## Configuration
- ALU_SEQ_ZFLAG_EN defined:
  - Adds output zero (1 bit), registered.
  - zero is set in the DONE cycle to (result == 0) and held with result.
  - zero resets to 0.
- ALU_SEQ_ZFLAG_EN not defined: the zero port and its logic are absent.

## Test plan
All scenarios use BYTES=4 with the sequencer driving a real ALU instance.
- Add: op=0100, opa=0x0000FFFF, opb=0x00000001, cin=0 -> result=0x00010000, cout=0; done 5 cycles after start; busy high 4 cycles.
- Add wrap: op=0100, opa=0xFFFFFFFF, opb=0x00000001 -> result=0x00000000, cout=1. With ALU_SEQ_ZFLAG_EN, zero=1.
- Shift left: op=1000, opa=0x80000001, cin=0 -> result=0x00000002, cout=1. Monitor confirms byte 0 first, with alu_op=1001 on bytes 1..3.
- Shift right: op=1100, opa=0x80000001, cin=0 -> result=0x40000000, cout=1. Monitor confirms byte 3 first.
- Handshake: pulse start again two cycles after an accepted add -> the second start is ignored, only one done pulse is seen, and the result matches the first operation.
- Reset abort: assert rst during cycle 2 of RUN -> busy, done and result go to 0 immediately, with no done pulse. A fresh add after release completes normally.
